// File: rtl/nfu_2_accum_pkg.sv
// nfu_pkg: shared constants, FSM state type and narrowing helper for the
// NFU-2 accumulate stage.
//   N       product / output element width (signed fixed point)
//   TN      neurons per tile, products per neuron (power of two, >= 2)
//   LOG2_TN adder-tree depth, log2(TN)
//   ACC_W   signed accumulator width, >= N + LOG2_TN
// sat_to_n is only called when NFU2_SAT_EN is defined.
package nfu_pkg;

    localparam int N       = 16;
    localparam int TN      = 16;
    localparam int LOG2_TN = 4;
    localparam int ACC_W   = 32;

    localparam int TREE_W  = N + LOG2_TN;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (N - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    // Clamp a full-width accumulator value into the signed N-bit range.
    function automatic logic [N-1:0] sat_to_n(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[N-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[N-1:0];
        end else begin
            return v[N-1:0];
        end
    endfunction

endpackage

// File: rtl/nfu_2_adder_tree.sv
// nfu_2_adder_tree: pipelined TN-input signed reduction for one neuron.
// LOG2_TN registered stages, one beat per cycle. A valid/first/last
// sideband travels alongside the data with the same latency.
// Ports:
//   clk, rst_n             clock, async active-low reset
//   i_valid/i_first/i_last beat qualifier and framing flags
//   i_products [N*TN]      the neuron's TN products, element j at [j*N +: N]
//   o_valid/o_first/o_last sideband at the tree output
//   o_any_valid            any stage currently holds a valid beat
//   o_sum [N+LOG2_TN]      exact sum of the TN products
module nfu_2_adder_tree #(
    parameter int N       = 16,
    parameter int TN      = 16,
    parameter int LOG2_TN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    input  logic                   i_first,
    input  logic                   i_last,
    input  logic [N*TN-1:0]        i_products,
    output logic                   o_valid,
    output logic                   o_first,
    output logic                   o_last,
    output logic                   o_any_valid,
    output logic [N+LOG2_TN-1:0]   o_sum
);

    localparam int W = N + LOG2_TN;

    // Heap-ordered tree: node k sums children 2k and 2k+1; children at or
    // beyond index TN are the (unregistered) leaves. Every internal node is
    // registered, so the root sits exactly LOG2_TN registers from the inputs.
    // Nodes are kept at the full output width; this is the same value as
    // growing one sign bit per level and is exact.
    logic signed [W-1:0] leaf [TN];
    logic signed [W-1:0] node [1:TN-1];
    logic signed [W-1:0] op_a [1:TN-1];
    logic signed [W-1:0] op_b [1:TN-1];

    logic [LOG2_TN-1:0] v_q;
    logic [LOG2_TN-1:0] f_q;
    logic [LOG2_TN-1:0] l_q;

    for (genvar j = 0; j < TN; j++) begin : g_leaf
        assign leaf[j] = W'(signed'(i_products[j*N +: N]));
    end

    for (genvar k = 1; k < TN; k++) begin : g_node
        if (2 * k >= TN) begin : g_from_leaf
            assign op_a[k] = leaf[2*k - TN];
            assign op_b[k] = leaf[2*k + 1 - TN];
        end else begin : g_from_node
            assign op_a[k] = node[2*k];
            assign op_b[k] = node[2*k + 1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k < TN; k++) begin
                node[k] <= '0;
            end
        end else begin
            for (int k = 1; k < TN; k++) begin
                node[k] <= op_a[k] + op_b[k];
            end
        end
    end

    // Flags are qualified by valid on entry so stray flags never leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            f_q <= '0;
            l_q <= '0;
        end else begin
            v_q[0] <= i_valid;
            f_q[0] <= i_valid & i_first;
            l_q[0] <= i_valid & i_last;
            for (int s = 1; s < LOG2_TN; s++) begin
                v_q[s] <= v_q[s-1];
                f_q[s] <= f_q[s-1];
                l_q[s] <= l_q[s-1];
            end
        end
    end

    assign o_valid     = v_q[LOG2_TN-1];
    assign o_first     = f_q[LOG2_TN-1];
    assign o_last      = l_q[LOG2_TN-1];
    assign o_any_valid = |v_q;
    assign o_sum       = node[1];

endmodule

// File: rtl/nfu_2_accum.sv
// nfu_2_accum: NFU-2 stage. Reduces each of TN product rows through a
// pipelined adder tree, accumulates row sums across a first..last framed
// sequence of beats and emits TN N-bit partial sums.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_valid           product beat valid
//   i_first, i_last   framing flags, qualified by i_valid
//   i_products        TN x TN products, neuron i at [i*TN*N +: TN*N]
//   o_valid           one-cycle result pulse
//   o_sums            neuron i result at [i*N +: N], held between pulses
//   o_busy            frame open or a beat is inside the tree
//   o_err             sticky framing error
//   i_err_clr         synchronous clear of o_err (a same-cycle set wins)
// Build option: define NFU2_SAT_EN to clamp results to the signed N-bit
// range; otherwise the low N accumulator bits are output.
//
// state | meaning
// IDLE  | no frame open; expecting a first beat
// ACCUM | frame open; accumulating until a last beat
module nfu_2_accum
    import nfu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic                 i_first,
    input  logic                 i_last,
    input  logic [N*TN*TN-1:0]   i_products,
    output logic                 o_valid,
    output logic [N*TN-1:0]      o_sums,
    output logic                 o_busy,
    output logic                 o_err,
    input  logic                 i_err_clr
);

    localparam int W = TREE_W;

    logic [TN*W-1:0] tree_sums;
    logic [TN-1:0]   sb_valid;
    logic [TN-1:0]   sb_first;
    logic [TN-1:0]   sb_last;
    logic [TN-1:0]   sb_any;
    logic [4*(TN-1)-1:0] unused_sb;

    for (genvar gi = 0; gi < TN; gi++) begin : g_tree
        nfu_2_adder_tree #(
            .N       (N),
            .TN      (TN),
            .LOG2_TN (LOG2_TN)
        ) u_tree (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_valid     (i_valid),
            .i_first     (i_first),
            .i_last      (i_last),
            .i_products  (i_products[gi*TN*N +: TN*N]),
            .o_valid     (sb_valid[gi]),
            .o_first     (sb_first[gi]),
            .o_last      (sb_last[gi]),
            .o_any_valid (sb_any[gi]),
            .o_sum       (tree_sums[gi*W +: W])
        );
    end

    // All trees carry identical sideband; instance 0 is authoritative and
    // the duplicates are left for synthesis to remove.
    assign unused_sb = {sb_valid[TN-1:1], sb_first[TN-1:1],
                        sb_last[TN-1:1], sb_any[TN-1:1]};

    logic t_valid;
    logic t_first;
    logic t_last;

    assign t_valid = sb_valid[0];
    assign t_first = sb_first[0];
    assign t_last  = sb_last[0];

    state_t state_q;
    state_t state_d;
    logic   acc_load;
    logic   acc_add;
    logic   emit;
    logic   err_set;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_load = 1'b0;
        acc_add  = 1'b0;
        emit     = 1'b0;
        err_set  = 1'b0;
        if (t_valid) begin
            unique case (state_q)
                IDLE: begin
                    if (t_first) begin
                        acc_load = 1'b1;
                        emit     = t_last;
                        state_d  = t_last ? IDLE : ACCUM;
                    end else begin
                        err_set  = 1'b1;
                    end
                end
                ACCUM: begin
                    if (t_first) begin
                        // Unterminated frame: abandon it and restart here.
                        err_set  = 1'b1;
                        acc_load = 1'b1;
                        emit     = t_last;
                        state_d  = t_last ? IDLE : ACCUM;
                    end else begin
                        acc_add  = 1'b1;
                        emit     = t_last;
                        if (t_last) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic signed [ACC_W-1:0] tree_ext [TN];
    logic signed [ACC_W-1:0] acc_q    [TN];
    logic signed [ACC_W-1:0] acc_d    [TN];
    logic        [N-1:0]     narrow   [TN];

    for (genvar gi = 0; gi < TN; gi++) begin : g_acc
        assign tree_ext[gi] = ACC_W'(signed'(tree_sums[gi*W +: W]));
        assign acc_d[gi]    = acc_load ? tree_ext[gi] : acc_q[gi] + tree_ext[gi];
`ifdef NFU2_SAT_EN
        assign narrow[gi]   = sat_to_n(acc_d[gi]);
`else
        assign narrow[gi]   = acc_d[gi][N-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TN; i++) begin
                acc_q[i] <= '0;
            end
        end else if (acc_load || acc_add) begin
            for (int i = 0; i < TN; i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Results are registered straight from the next-accumulator value so
    // the output lands one cycle after the beat leaves the tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_sums  <= '0;
        end else begin
            o_valid <= emit;
            if (emit) begin
                for (int i = 0; i < TN; i++) begin
                    o_sums[i*N +: N] <= narrow[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_err <= 1'b0;
        end else if (err_set) begin
            o_err <= 1'b1;
        end else if (i_err_clr) begin
            o_err <= 1'b0;
        end
    end

    assign o_busy = (state_q == ACCUM) | sb_any[0];

endmodule

// File: doc/nfu_2_accum.md
Name: nfu_2_accum

Overview:
- NFU-2 stage, directly downstream of the NFU-1 multiplier array.
- Consumes the Tn x Tn product matrix; each row i holds neuron i's Tn products.
- Reduces each row through a pipelined adder tree, then accumulates the row sums across successive input chunks (first/last framing).
- Emits Tn N-bit neuron partial sums to the NFU-3 stage once per framed accumulation.

Parameters:
N, 16, product and output element width (signed fixed point)
TN, 16, neurons per tile and products per neuron; power of two, >= 2
LOG2_TN, 4, adder-tree depth; must equal log2(TN)
ACC_W, 32, signed accumulator width; must be >= N+LOG2_TN

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
i_valid  in  1  product beat valid this cycle
i_first  in  1  beat starts a new accumulation; qualified by i_valid
i_last  in  1  beat ends the accumulation; qualified by i_valid
i_products  in  N*TN*TN  row-major products; neuron i occupies bits [(i+1)*TN*N-1 : i*TN*N]
o_valid  out  1  one-cycle pulse; o_sums holds a result
o_sums  out  N*TN  neuron i result at bits [(i+1)*N-1 : i*N]
o_busy  out  1  FSM in ACCUM, or any tree stage holds a valid beat
o_err  out  1  sticky framing-error flag
i_err_clr  in  1  synchronous clear of o_err

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: o_valid=0, o_sums=0, o_busy=0, o_err=0. Tree valids, accumulators and chunk state are cleared; FSM enters IDLE.
- Reset mid-operation: all in-flight beats and partial sums are discarded; no output is produced for them.
- Adder tree: LOG2_TN registered stages, one valid bit per stage, fully pipelined, 1 beat/cycle.
  - Operands are sign-extended by 1 bit per level; the tree output is N+LOG2_TN bits and is exact.
  - The first/last flags travel with the valid bit.
- Accumulate stage: the tree output is sign-extended to ACC_W.
  - If the beat is flagged first: acc <= tree.
  - Otherwise: acc <= acc + tree, wrapping modulo 2^ACC_W.
- FSM, evaluated on beats leaving the tree:
  - IDLE, first&last: compute a single-chunk result, emit it, stay in IDLE.
  - IDLE, first only: load acc, go to ACCUM.
  - IDLE, beat without first: drop the beat, set o_err, stay in IDLE.
  - ACCUM, middle beat: accumulate.
  - ACCUM, last: accumulate, emit, go to IDLE.
  - ACCUM, first: discard the old acc, set o_err, reload acc (re-enter ACCUM, or emit if last is also set).
- Output: o_sums and o_valid are registered from the final accumulated value. A beat with i_last at cycle t gives o_valid=1 in cycle t+LOG2_TN+1 (5 for defaults).
- Narrowing ACC_W to N bits follows the optional feature below. o_sums holds its value between pulses.
- Throughput: back-to-back single-chunk frames produce o_valid on consecutive cycles. There is no backpressure; the consumer must accept every pulse.
- o_err: when an error set and i_err_clr occur in the same cycle, set wins.
- i_first/i_last are ignored when i_valid=0.

Optional Feature:
- Macro: NFU2_SAT_EN.
- Defined: each neuron result is clamped to [-2^(N-1), 2^(N-1)-1] when narrowed to N bits.
- Undefined: the low N bits of the accumulator are output (wrap).
- The accumulator itself always wraps at ACC_W.

Decomposition:
- Package nfu_pkg holds:
  - constants N, TN, LOG2_TN, ACC_W;
  - the FSM state enum {IDLE, ACCUM};
  - a saturate-to-N function used under NFU2_SAT_EN.
- Sub-module nfu_2_adder_tree: per-neuron pipelined TN-input reduction with a valid/flag sideband. It is instantiated TN times; only instance 0's sideband is used.
- The FSM, accumulators and output register live in nfu_2_accum.

Test Plan:
- Single frame: first&last, every product of neuron k = k (k=0..15) at t=0 -> o_valid at t=5 only, o_sums[k]=16k.
- Three-chunk frame: products all 1 over 3 beats (first, mid, last) -> one o_valid pulse, every o_sums element = 48, o_busy low after the pulse.
- Saturation: single beat, all products 0x7FFF -> o_sums = 0x7FFF with NFU2_SAT_EN, 0xFFF0 without. All products 0x8000 -> 0x8000 with the macro, 0x0000 without.
- Framing error: valid beat without first while IDLE -> no o_valid, o_err=1 from the following cycle. Pulse i_err_clr -> o_err=0. A subsequent good frame is unaffected.
- Reset mid-accumulation:
  - Stimulus: two beats of 1s (first, mid), assert rst_n=0 for 2 cycles, then one first&last beat of 2s.
  - Response: all outputs 0 during reset, then a single o_valid with o_sums=32 per neuron.
- Back-to-back: four consecutive first&last beats with values 1,2,3,4 -> o_valid on 4 consecutive cycles, o_sums = 16,32,48,64.
